// File: rtl/fir_pkg.sv
// Shared definitions for the fir filter sequencer: state encoding and default widths.
package fir_pkg;

  localparam int FIR_DATA_W = 8;
  localparam int FIR_OUT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COEF   = 3'd1,
    ST_GAP    = 3'd2,
    ST_STREAM = 3'd3,
    ST_ERR    = 3'd4
  } fir_drv_state_t;

endpackage

// File: rtl/fir_result_fifo.sv
// Result buffer between the fir output strobe and the downstream valid/ready port.
// A push at full is taken only when a pop happens in the same cycle.
module fir_result_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Output reads as zero while empty so out_data idles at its reset value.
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fir_driver.sv
// Sequencer for the fir block: coefficient load, one idle gap, credit-limited sample
// stream, and buffered return of fir results over valid/ready.
module fir_driver
  import fir_pkg::*;
#(
  parameter int NUM_COEF   = 5,
  parameter int DATA_W     = FIR_DATA_W,
  parameter int OUT_W      = FIR_OUT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_coef,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] fir_data_in,
  output logic              fir_coef_enable,
  output logic              fir_sample_enable,
  input  logic [OUT_W-1:0]  fir_data_out,
  input  logic              fir_out_enable,
  input  logic              fir_error,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(NUM_COEF) + 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a word moves on any rising edge where valid and ready are both high.
  fir_drv_state_t    state_q, state_d;
  logic [CNT_W-1:0]  coef_cnt_q, coef_cnt_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [DATA_W-1:0] fir_data_q, fir_data_d;
  logic              coef_en_q, coef_en_d;
  logic              samp_en_q, samp_en_d;
  logic              err_q, err_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic              issue;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       in_flight;
  logic              credit_ok;

  fir_result_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (fir_out_enable),
    .push_data_i (fir_data_out),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = fir_out_enable && fifo_full && !pop;

  // Every result slot is either buffered or still inside the fir pipeline.
  assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit_ok = (in_flight < (CW + 1)'(FIFO_DEPTH));

  always_comb begin
    case (state_q)
      ST_COEF:   in_ready = 1'b1;
      ST_STREAM: in_ready = credit_ok;
      default:   in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    coef_cnt_d = coef_cnt_q;
    fir_data_d = fir_data_q;
    coef_en_d  = 1'b0;
    samp_en_d  = 1'b0;
    err_d      = err_q;
    overrun_d  = overrun_q;
    issue      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_coef) begin
          state_d    = ST_COEF;
          coef_cnt_d = '0;
          err_d      = 1'b0;
          overrun_d  = 1'b0;
        end
      end
      ST_COEF: begin
        if (accept) begin
          fir_data_d = in_data;
          coef_en_d  = 1'b1;
          if (coef_cnt_q == CNT_W'(NUM_COEF - 1)) begin
            state_d    = ST_GAP;
            coef_cnt_d = '0;
          end else begin
            coef_cnt_d = coef_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_GAP: state_d = ST_STREAM;
      ST_STREAM: begin
        // A word accepted alongside a reload is still issued; its result is captured.
        if (accept) begin
          fir_data_d = in_data;
          samp_en_d  = 1'b1;
          issue      = 1'b1;
        end
        if (load_coef) begin
          state_d    = ST_COEF;
          coef_cnt_d = '0;
          err_d      = 1'b0;
          overrun_d  = 1'b0;
        end
      end
      ST_ERR: begin
        if (load_coef) begin
          state_d    = ST_COEF;
          coef_cnt_d = '0;
          err_d      = 1'b0;
          overrun_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (drop) overrun_d = 1'b1;

    // Error overrides any reload or accept in the same cycle.
    if (fir_error) begin
      state_d    = ST_ERR;
      err_d      = 1'b1;
      coef_en_d  = 1'b0;
      samp_en_d  = 1'b0;
      issue      = 1'b0;
      fir_data_d = fir_data_q;
    end
  end

  always_comb begin
    case ({issue, fir_out_enable})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = (outstanding_q == '0) ? '0 : outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      coef_cnt_q    <= '0;
      outstanding_q <= '0;
      fir_data_q    <= '0;
      coef_en_q     <= 1'b0;
      samp_en_q     <= 1'b0;
      err_q         <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      coef_cnt_q    <= coef_cnt_d;
      outstanding_q <= outstanding_d;
      fir_data_q    <= fir_data_d;
      coef_en_q     <= coef_en_d;
      samp_en_q     <= samp_en_d;
      err_q         <= err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign fir_data_in       = fir_data_q;
  assign fir_coef_enable   = coef_en_q;
  assign fir_sample_enable = samp_en_q;
  assign busy              = (state_q != ST_IDLE);
  assign err               = err_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_fir_driver.sv
// Directed bench for fir_driver with a behavioural 5-tap fir (2-cycle latency) attached.
module tb_fir_driver;

  typedef int coef_arr_t[5];
  typedef int hist_arr_t[4];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_coef = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  fir_data_in;
  logic        fir_coef_enable;
  logic        fir_sample_enable;
  logic [15:0] fir_data_out;
  logic        fir_out_enable;
  logic        fir_error = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        err;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  coef_arr_t b_coef = '{default: 0};
  hist_arr_t b_hist = '{default: 0};

  coef_arr_t   m_coef = '{default: 0};
  hist_arr_t   m_hist;
  int          m_cidx;
  logic        p1_v;
  logic [15:0] p1_d;
  logic        m_out_v;
  logic [15:0] m_out_d;
  logic        inj_oe = 1'b0;
  logic [15:0] inj_data = '0;

  fir_driver dut (
    .clk               (clk),
    .reset             (reset),
    .load_coef         (load_coef),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .fir_data_in       (fir_data_in),
    .fir_coef_enable   (fir_coef_enable),
    .fir_sample_enable (fir_sample_enable),
    .fir_data_out      (fir_data_out),
    .fir_out_enable    (fir_out_enable),
    .fir_error         (fir_error),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .busy              (busy),
    .err               (err),
    .overrun           (overrun)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] fir_sum(input coef_arr_t c, input int x0, input hist_arr_t h);
    int s;
    s = c[0] * x0 + c[1] * h[0] + c[2] * h[1] + c[3] * h[2] + c[4] * h[3];
    return s[15:0];
  endfunction

  // ---------------- behavioural fir ----------------
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cidx  <= 0;
      m_hist  <= '{default: 0};
      p1_v    <= 1'b0;
      p1_d    <= '0;
      m_out_v <= 1'b0;
      m_out_d <= '0;
    end else begin
      if (fir_coef_enable) begin
        m_coef[m_cidx] <= int'(fir_data_in);
        m_cidx <= (m_cidx == 4) ? 0 : m_cidx + 1;
      end
      p1_v <= fir_sample_enable;
      if (fir_sample_enable) begin
        p1_d      <= fir_sum(m_coef, int'(fir_data_in), m_hist);
        m_hist[0] <= int'(fir_data_in);
        m_hist[1] <= m_hist[0];
        m_hist[2] <= m_hist[1];
        m_hist[3] <= m_hist[2];
      end
      m_out_v <= p1_v;
      m_out_d <= p1_d;
    end
  end

  assign fir_out_enable = m_out_v | inj_oe;
  assign fir_data_out   = inj_oe ? inj_data : m_out_d;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic push_exp(input logic [7:0] v);
    exp_q.push_back(fir_sum(b_coef, int'(v), b_hist));
    b_hist[3] = b_hist[2];
    b_hist[2] = b_hist[1];
    b_hist[1] = b_hist[0];
    b_hist[0] = int'(v);
  endtask

  task automatic send_word(input string tag, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int w = 0; w < 20; w++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    chk({tag, "_accepted"}, 32'(ok), 32'd1);
  endtask

  task automatic drain_one(input string tag);
    bit got;
    logic [15:0] e;
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk(tag, 32'(out_data), 32'(e));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        got = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_arrived"}, 32'(got), 32'd1);
  endtask

  task automatic load_all_coefs(input string tag);
    for (int i = 0; i < 5; i++) begin
      send_word(tag, 8'(4 + i));
      b_coef[i] = 4 + i;
      chk({tag, "_coef_en"}, 32'(fir_coef_enable), 32'd1);
      chk({tag, "_coef_data"}, 32'(fir_data_in), 32'(4 + i));
      chk({tag, "_samp_en"}, 32'(fir_sample_enable), 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    logic [7:0] v;

    // reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_coef_en", 32'(fir_coef_enable), 0);
    chk("rst_samp_en", 32'(fir_sample_enable), 0);
    chk("rst_data_in", 32'(fir_data_in), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 0);

    // coefficient load
    load_coef = 1'b1;
    tick();
    load_coef = 1'b0;
    chk("coef_in_ready", 32'(in_ready), 1);
    chk("coef_busy", 32'(busy), 1);
    load_all_coefs("load1");
    chk("gap_entry_in_ready", 32'(in_ready), 0);
    tick();
    chk("gap_coef_en", 32'(fir_coef_enable), 0);
    chk("gap_samp_en", 32'(fir_sample_enable), 0);
    chk("stream_in_ready", 32'(in_ready), 1);
    chk("stream_busy", 32'(busy), 1);

    // stream of ones, one result drained per sample
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_word("ones", 8'd1);
      push_exp(8'd1);
      chk("ones_samp_en", 32'(fir_sample_enable), 1);
      chk("ones_coef_en", 32'(fir_coef_enable), 0);
      drain_one("ones_result");
    end
    chk("ones_overrun", 32'(overrun), 0);

    // backpressure: credits run out after four samples
    acc = 0;
    v = 8'd2;
    in_data = v;
    in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (in_ready) begin
        push_exp(v);
        acc++;
        tick();
        v = v + 8'd1;
        in_data = v;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 4);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    for (int i = 0; i < 4; i++) drain_one("bp_result");
    chk("bp_in_ready_back", 32'(in_ready), 1);

    // overrun: five results against a four-entry buffer
    for (int i = 0; i < 5; i++) begin
      inj_oe = 1'b1;
      inj_data = 16'hA000 + 16'(i);
      if (i < 4) exp_q.push_back(16'hA000 + 16'(i));
      tick();
    end
    inj_oe = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_in_ready", 32'(in_ready), 0);

    // reload from STREAM clears overrun and enters COEF at once
    load_coef = 1'b1;
    tick();
    load_coef = 1'b0;
    chk("reload_in_ready", 32'(in_ready), 1);
    chk("reload_overrun", 32'(overrun), 0);
    for (int i = 0; i < 4; i++) drain_one("ovr_result");
    load_all_coefs("load2");

    // async reset between edges mid-stream
    send_word("pre_rst", 8'd7);
    chk("pre_rst_samp_en", 32'(fir_sample_enable), 1);
    #3 reset = 1'b0;
    #1;
    chk("arst_samp_en", 32'(fir_sample_enable), 0);
    chk("arst_coef_en", 32'(fir_coef_enable), 0);
    chk("arst_data_in", 32'(fir_data_in), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_overrun", 32'(overrun), 0);
    exp_q.delete();
    b_hist = '{default: 0};
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // error during the third coefficient word
    load_coef = 1'b1;
    tick();
    load_coef = 1'b0;
    send_word("err_w1", 8'd1);
    send_word("err_w2", 8'd2);
    chk("err_w3_ready", 32'(in_ready), 1);
    in_data = 8'd3;
    in_valid = 1'b1;
    fir_error = 1'b1;
    tick();
    in_valid = 1'b0;
    fir_error = 1'b0;
    chk("err_flag", 32'(err), 1);
    chk("err_coef_en", 32'(fir_coef_enable), 0);
    chk("err_samp_en", 32'(fir_sample_enable), 0);
    chk("err_in_ready", 32'(in_ready), 0);
    chk("err_busy", 32'(busy), 1);
    tick();
    chk("err_sticky", 32'(err), 1);
    load_coef = 1'b1;
    fir_error = 1'b1;
    tick();
    load_coef = 1'b0;
    fir_error = 1'b0;
    chk("err_wins_in_ready", 32'(in_ready), 0);
    chk("err_wins_err", 32'(err), 1);
    load_coef = 1'b1;
    tick();
    load_coef = 1'b0;
    chk("err_restart_in_ready", 32'(in_ready), 1);
    chk("err_cleared", 32'(err), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_driver.md
# fir_driver

Sequencer that drives the coefficient-load and sample-stream protocol of the `fir` filter block and collects its results. It accepts an upstream valid/ready byte stream and issues the coefficient words with `coef_enable`, inserts the mandatory idle gap, then feeds samples with `sample_enable`. FIR outputs qualified by `out_enable` are buffered and returned downstream through valid/ready. It sits between a host/DMA byte source and one `fir` instance.

## Interface
- `NUM_COEF`, 5: coefficient words per load phase.
- `DATA_W`, 8: sample/coefficient width, matches `fir` `data_in`.
- `OUT_W`, 16: result width, matches `fir` `data_out`.
- `FIFO_DEPTH`, 4: result buffer entries, power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_coef`  in  1  one-cycle request to start a coefficient load.
- `in_data`  in  DATA_W  upstream word.
- `in_valid` in 1 / `in_ready` out 1: upstream handshake.
- `fir_data_in`  out  DATA_W  to `fir.data_in`.
- `fir_coef_enable`  out  1  to `fir.coef_enable`.
- `fir_sample_enable`  out  1  to `fir.sample_enable`.
- `fir_data_out`  in  OUT_W  from `fir.data_out`.
- `fir_out_enable`  in  1  from `fir.out_enable`.
- `fir_error`  in  1  from `fir.error`.
- `out_data` out OUT_W / `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `busy`  out  1  state ≠ IDLE.
- `err`  out  1  sticky, FIR reported error.
- `overrun`  out  1  sticky, result dropped on full FIFO.

## Operation
- States: IDLE, COEF, GAP, STREAM, ERR.
- IDLE: `in_ready`=0. `load_coef` → COEF, clears `err`, `overrun`, coefficient counter.
- COEF: `in_ready`=1. Each accepted word registered onto `fir_data_in` with `fir_coef_enable`=1 for exactly the following cycle. After `NUM_COEF` accepts → GAP. `load_coef` ignored.
- GAP: one cycle, `in_ready`=0, both enables 0 → STREAM.
- STREAM: `in_ready` = (credits > 0). Accepted word registered onto `fir_data_in` with `fir_sample_enable`=1 for one cycle. `load_coef` → COEF immediately; in-flight results still captured.
- Credits: `FIFO_DEPTH − fifo_count − outstanding`. `outstanding` increments per issued sample and decrements per captured result, saturating at 0.
- Capture: every cycle with `fir_out_enable`=1, push `fir_data_out`. If the FIFO is full, drop the result and set `overrun`.
- `fir_error` sampled 1 in any state → ERR. `err`=1, enables 0, `in_ready`=0. ERR exits only on `load_coef` → COEF. FIFO keeps draining.
- Enables are never both 1. No accept means both enables are 0 in the next cycle. `fir_data_in` holds its last value.

## Timing
- Reset values: all enables 0, `fir_data_in`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `err`=0, `overrun`=0, FIFO empty, state IDLE.
- Accept at edge k means FIR enable/data are valid between edges k and k+1, and the FIR samples them at k+1.
- `load_coef` at edge k: COEF at k, so `in_ready`=1 in cycle k+1.
- Capture-to-`out_valid`: 1 cycle, registered. Push and pop in the same cycle are both allowed at full.
- `reset` asserted mid-operation clears everything asynchronously. Coefficients loaded into the FIR are not re-sent.
- `fir_error` and `load_coef` in the same cycle: error wins.

## Structure
- Shared package `fir_pkg`: state enum `fir_drv_state_t`, default width constants `FIR_DATA_W`=8 and `FIR_OUT_W`=16.
- Sub-module `fir_result_fifo`: synchronous FIFO of `OUT_W` × `FIFO_DEPTH` with count output. The FSM, counters and credit logic live in `fir_driver`.

## Test plan
- **Coefficient load:** reset, `load_coef`, words 4,5,6,7,8 back-to-back → five consecutive `fir_coef_enable` cycles with `fir_data_in` 4..8, then exactly one gap cycle, then `busy`=1 with `in_ready`=1.
- **Stream, 2-cycle latency:** after the load, five samples of value 1 against a behavioural FIR model → five `sample_enable` pulses and five results drained in order. `out_data` = model sums, `overrun`=0.
- **Backpressure:** `out_ready`=0, samples offered continuously → `in_ready` drops after 4 issued samples. Releasing `out_ready` drains 4 results and `in_ready` recovers.
- **Error:** model asserts `fir_error` during COEF word 3 → `err`=1, enables 0 from the next cycle, `in_ready`=0. `load_coef` then restarts COEF and clears `err`.
- **Overrun and mid-stream reload:** model emits `out_enable` with the FIFO full → `overrun`=1. `load_coef` during STREAM → COEF next cycle and `overrun` cleared.
- **Async reset:** assert `reset`=0 mid-STREAM between clock edges → all outputs at reset values immediately.
